tron_match_fsm: RTL and testbench
=================================

# tron_match_fsm

Parametrised match controller for the Tron game: an N-player, multi-map, best-of-K state machine. It replaces the fixed two-player menu/round/win sequencer. It sits between the keyboard keycode register, the per-player collision detectors and the background loader/renderer. It tracks alive players and per-player round scores, selects the map with wrap-around, and pulses background reloads.

## Interface
- NUM_PLAYERS, 2: number of bikes, 2..4.
- NUM_MAPS, 2: number of playable maps, 1..7. Map 0 is the menu/win screen.
- ROUNDS_TO_WIN, 3: round wins needed to take the match, 1..15.
- Derived (localparam): PW = $clog2(NUM_PLAYERS); BW = $clog2(NUM_MAPS+1); SW = $clog2(ROUNDS_TO_WIN+1).
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Reset_Game  in  1  synchronous match abort, returns to MENU.
- Reset_Round  in  1  synchronous round restart; honoured only in ROUND_STARTED.
- Player_Dead  in  NUM_PLAYERS  per-player collision flag; may be a level or a pulse.
- keycode  in  8  current USB HID keycode; 0 = none.
- Game_State  out  3  encoded state: MENU=0, ROUND_PAUSED=1, ROUND_STARTED=2, ROUND_OVER=3, MATCH_OVER=4.
- background_select  out  BW  0 in MENU/MATCH_OVER, otherwise the chosen map (1..NUM_MAPS).
- menu_cursor  out  BW  map highlighted in the menu (1..NUM_MAPS).
- load_background  out  1  one-cycle registered reload pulse.
- Alive  out  NUM_PLAYERS  players still alive in the current round.
- Scores  out  NUM_PLAYERS*SW  packed per-player round wins; player i occupies bits [i*SW +: SW].
- Winner  out  PW  last round/match winner; valid in ROUND_OVER/MATCH_OVER.
- Draw  out  1  last round ended with no survivor.

## Operation
- Key edge: key_evt = (keycode != 0) && (keycode != keycode_q); keycode_q is registered every cycle.
  - Every key action below requires key_evt, so a held key acts once.
- MENU:
  - Up (0x1A, 0x52): menu_cursor+1, wrapping NUM_MAPS→1.
  - Down (0x16, 0x51): menu_cursor−1, wrapping 1→NUM_MAPS.
  - Enter (0x28): go to ROUND_PAUSED; latch map = menu_cursor; clear Scores, Winner, Draw; pulse load_background.
- ROUND_PAUSED:
  - Alive held all-ones.
  - Any key_evt → ROUND_STARTED.
- ROUND_STARTED:
  - Each cycle, alive_nxt = Alive & ~Player_Dead.
  - If popcount(alive_nxt) ≤ 1:
    - Exactly one survivor: it scores +1 and sets Winner.
    - Zero survivors: Draw=1 and no score.
    - If the survivor's new score == ROUNDS_TO_WIN → MATCH_OVER; else → ROUND_OVER.
  - Reset_Round has priority over deaths in the same cycle: → ROUND_PAUSED, no score, pulse load_background.
- ROUND_OVER: any key_evt → ROUND_PAUSED, Draw cleared, pulse load_background.
- MATCH_OVER: any key_evt → MENU, pulse load_background. Scores are held until the next Enter.
- Reset_Game (any state): → MENU next edge, Scores cleared, menu_cursor kept, no load_background pulse.
  - Reset_Game has priority over every other input.
- Scores saturate at ROUNDS_TO_WIN and never wrap.
- Unused encodings 5..7 → MENU.

## Timing
- Reset_n low, effective immediately:
  - Game_State=0, background_select=0, menu_cursor=1, map=1.
  - load_background=0, Alive=all-ones, Scores=0, Winner=0, Draw=0, keycode_q=0.
- Every transition takes effect on the edge after the qualifying input (1-cycle latency).
- load_background is high in exactly the first cycle of the new state.
- Score, Winner and Draw update on the same edge as the ROUND_STARTED exit.
- Player_Dead is ignored outside ROUND_STARTED.
- A keycode arriving on the edge of a state change is evaluated in the old state only. It cannot chain two transitions.

## Structure
- tron_pkg holds:
  - typedef enum logic [2:0] game_state_t;
  - keycode constants KEY_ENTER, KEY_W, KEY_S, KEY_UP, KEY_DOWN.
- Sub-module key_edge_detect (keycode in; key_evt and keycode_q out), reusable by the menu and the bike controllers.
- Popcount and survivor index: a combinational function in this module.

## Test plan
- Reset_n low mid-ROUND_STARTED → all outputs at reset values without waiting for a Clk edge.
- MENU, NUM_MAPS=3, three Up edges → menu_cursor 2,3,1; Up held 10 cycles → one increment only.
- Enter, then key 0x04 → ROUND_PAUSED then ROUND_STARTED; load_background high exactly one cycle; background_select=cursor.
- NUM_PLAYERS=4: Player_Dead=0001, then 0100, then 1000 → Alive 1110, 1010, then ROUND_OVER with Winner=1, Scores[1]=1.
- Same-cycle deaths of both last players → ROUND_OVER, Draw=1, Scores unchanged; Reset_Round together with a death → ROUND_PAUSED, no score.
- ROUNDS_TO_WIN=2: player 0 wins two rounds → MATCH_OVER, Winner=0, Scores[0]=2; a key press → MENU, background_select=0.

Source files
------------

// File: rtl/tron_pkg.sv
// rtl/tron_pkg.sv - shared state encoding and keycode constants for the Tron match controller
package tron_pkg;

  typedef enum logic [2:0] {
    S_MENU          = 3'd0,
    S_ROUND_PAUSED  = 3'd1,
    S_ROUND_STARTED = 3'd2,
    S_ROUND_OVER    = 3'd3,
    S_MATCH_OVER    = 3'd4
  } game_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;

  // W and the arrow keys are aliases so either hand can drive the menu.
  function automatic logic key_is_up(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_UP);
  endfunction

  function automatic logic key_is_down(input logic [7:0] k);
    return (k == KEY_S) || (k == KEY_DOWN);
  endfunction

endpackage

// File: rtl/tron_match_fsm_if.sv
// rtl/tron_match_fsm_if.sv - match controller signal bundle; master = match FSM, slave = game logic around it
interface tron_match_fsm_if #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_MAPS      = 2,
  parameter int ROUNDS_TO_WIN = 3
);
  localparam int PW = $clog2(NUM_PLAYERS);
  localparam int BW = $clog2(NUM_MAPS + 1);
  localparam int SW = $clog2(ROUNDS_TO_WIN + 1);

  logic                      Reset_Game;
  logic                      Reset_Round;
  logic [NUM_PLAYERS-1:0]    Player_Dead;
  logic [7:0]                keycode;

  logic [2:0]                Game_State;
  logic [BW-1:0]             background_select;
  logic [BW-1:0]             menu_cursor;
  logic                      load_background;
  logic [NUM_PLAYERS-1:0]    Alive;
  logic [NUM_PLAYERS*SW-1:0] Scores;
  logic [PW-1:0]             Winner;
  logic                      Draw;

  modport master (
    input  Reset_Game, Reset_Round, Player_Dead, keycode,
    output Game_State, background_select, menu_cursor, load_background,
           Alive, Scores, Winner, Draw
  );

  modport slave (
    output Reset_Game, Reset_Round, Player_Dead, keycode,
    input  Game_State, background_select, menu_cursor, load_background,
           Alive, Scores, Winner, Draw
  );

endinterface

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - turns a level HID keycode into a one-shot event per distinct key press
module key_edge_detect (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] keycode_i,
  output logic       key_evt_o,
  output logic [7:0] keycode_q_o
);

  logic [7:0] keycode_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      keycode_q <= 8'h00;
    end else begin
      keycode_q <= keycode_i;
    end
  end

  // A held key matches last cycle's code, so only its first cycle fires.
  assign key_evt_o   = (keycode_i != 8'h00) && (keycode_i != keycode_q);
  assign keycode_q_o = keycode_q;

endmodule

// File: rtl/tron_match_fsm.sv
// rtl/tron_match_fsm.sv - N-player, multi-map, best-of-K match sequencer for Tron
module tron_match_fsm #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_MAPS      = 2,
  parameter int ROUNDS_TO_WIN = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  tron_match_fsm_if.master  bus
);
  import tron_pkg::*;

  localparam int PW = $clog2(NUM_PLAYERS);
  localparam int BW = $clog2(NUM_MAPS + 1);
  localparam int SW = $clog2(ROUNDS_TO_WIN + 1);

  localparam logic [NUM_PLAYERS-1:0] ALL_ALIVE = '1;
  localparam logic [SW-1:0]          SCORE_MAX = SW'(ROUNDS_TO_WIN);
  localparam logic [BW-1:0]          MAP_FIRST = BW'(1);
  localparam logic [BW-1:0]          MAP_LAST  = BW'(NUM_MAPS);
  localparam logic [PW:0]            ONE_LEFT  = (PW+1)'(1);

  // Returns {live count, index of lowest live player}; the index only matters when the count is 1.
  function automatic logic [2*PW:0] survivor_info(input logic [NUM_PLAYERS-1:0] v);
    logic [PW:0]   n;
    logic [PW-1:0] idx;
    n   = '0;
    idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      n = n + (PW+1)'(v[i]);
      if (v[i]) idx = PW'(i);
    end
    return {n, idx};
  endfunction

  logic       key_evt;
  logic [7:0] keycode_q_unused;

  key_edge_detect u_key_edge (
    .clk_i       (Clk),
    .rst_ni      (Reset_n),
    .keycode_i   (bus.keycode),
    .key_evt_o   (key_evt),
    .keycode_q_o (keycode_q_unused)
  );

  game_state_t               state_q;
  logic [BW-1:0]             map_q;
  logic [BW-1:0]             cursor_q;
  logic [BW-1:0]             bg_q;
  logic                      load_q;
  logic [NUM_PLAYERS-1:0]    alive_q;
  logic [NUM_PLAYERS*SW-1:0] scores_q;
  logic [PW-1:0]             winner_q;
  logic                      draw_q;

  logic [NUM_PLAYERS-1:0]    alive_d;
  logic [PW:0]               n_alive;
  logic [PW-1:0]             surv_idx;
  logic [SW-1:0]             surv_score;
  logic [SW-1:0]             surv_score_d;
  logic [NUM_PLAYERS*SW-1:0] scores_d;
  logic [BW-1:0]             cursor_up_d;
  logic [BW-1:0]             cursor_dn_d;

  always_comb begin
    alive_d               = alive_q & ~bus.Player_Dead;
    {n_alive, surv_idx}   = survivor_info(alive_d);
    surv_score            = scores_q[surv_idx*SW +: SW];
    // Saturate so a stray extra win can never wrap a score back to zero.
    surv_score_d          = (surv_score >= SCORE_MAX) ? surv_score : surv_score + SW'(1);
    scores_d              = scores_q;
    scores_d[surv_idx*SW +: SW] = surv_score_d;
    cursor_up_d           = (cursor_q == MAP_LAST)  ? MAP_FIRST : cursor_q + BW'(1);
    cursor_dn_d           = (cursor_q == MAP_FIRST) ? MAP_LAST  : cursor_q - BW'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_MENU;
      map_q    <= MAP_FIRST;
      cursor_q <= MAP_FIRST;
      bg_q     <= '0;
      load_q   <= 1'b0;
      alive_q  <= ALL_ALIVE;
      scores_q <= '0;
      winner_q <= '0;
      draw_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (bus.Reset_Game) begin
        // Abort is silent: no reload pulse, and the menu cursor survives.
        state_q  <= S_MENU;
        bg_q     <= '0;
        alive_q  <= ALL_ALIVE;
        scores_q <= '0;
      end else begin
        case (state_q)
          S_MENU: begin
            if (key_evt) begin
              if (key_is_up(bus.keycode)) begin
                cursor_q <= cursor_up_d;
              end else if (key_is_down(bus.keycode)) begin
                cursor_q <= cursor_dn_d;
              end else if (bus.keycode == KEY_ENTER) begin
                state_q  <= S_ROUND_PAUSED;
                map_q    <= cursor_q;
                bg_q     <= cursor_q;
                load_q   <= 1'b1;
                alive_q  <= ALL_ALIVE;
                scores_q <= '0;
                winner_q <= '0;
                draw_q   <= 1'b0;
              end
            end
          end

          S_ROUND_PAUSED: begin
            alive_q <= ALL_ALIVE;
            if (key_evt) begin
              state_q <= S_ROUND_STARTED;
            end
          end

          S_ROUND_STARTED: begin
            if (bus.Reset_Round) begin
              state_q <= S_ROUND_PAUSED;
              alive_q <= ALL_ALIVE;
              load_q  <= 1'b1;
            end else begin
              alive_q <= alive_d;
              if (n_alive == ONE_LEFT) begin
                scores_q <= scores_d;
                winner_q <= surv_idx;
                draw_q   <= 1'b0;
                if (surv_score_d == SCORE_MAX) begin
                  state_q <= S_MATCH_OVER;
                  bg_q    <= '0;
                end else begin
                  state_q <= S_ROUND_OVER;
                end
              end else if (n_alive < ONE_LEFT) begin
                draw_q  <= 1'b1;
                state_q <= S_ROUND_OVER;
              end
            end
          end

          S_ROUND_OVER: begin
            if (key_evt) begin
              state_q <= S_ROUND_PAUSED;
              alive_q <= ALL_ALIVE;
              draw_q  <= 1'b0;
              load_q  <= 1'b1;
            end
          end

          S_MATCH_OVER: begin
            if (key_evt) begin
              state_q <= S_MENU;
              bg_q    <= '0;
              load_q  <= 1'b1;
            end
          end

          default: begin
            state_q <= S_MENU;
            bg_q    <= '0;
          end
        endcase
      end
    end
  end

  assign bus.Game_State        = state_q;
  assign bus.background_select = bg_q;
  assign bus.menu_cursor       = cursor_q;
  assign bus.load_background   = load_q;
  assign bus.Alive             = alive_q;
  assign bus.Scores            = scores_q;
  assign bus.Winner            = winner_q;
  assign bus.Draw              = draw_q;

endmodule

// File: tb/tb_tron_match_fsm.sv
// tb/tb_tron_match_fsm.sv - directed bench for tron_match_fsm with 4 players, 3 maps, first to 2
module tb_tron_match_fsm;

  logic Clk;
  logic Reset_n;
  int   nerr;
  int   nchk;

  tron_match_fsm_if #(.NUM_PLAYERS(4), .NUM_MAPS(3), .ROUNDS_TO_WIN(2)) bus ();

  tron_match_fsm #(.NUM_PLAYERS(4), .NUM_MAPS(3), .ROUNDS_TO_WIN(2)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    bus.keycode = k;
    step(1);
  endtask

  task automatic release_key();
    bus.keycode = 8'h00;
    step(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},  32'(bus.Game_State), 0);
    chk({tag, "_bg"},     32'(bus.background_select), 0);
    chk({tag, "_cursor"}, 32'(bus.menu_cursor), 1);
    chk({tag, "_load"},   32'(bus.load_background), 0);
    chk({tag, "_alive"},  32'(bus.Alive), 32'hF);
    chk({tag, "_scores"}, 32'(bus.Scores), 0);
    chk({tag, "_winner"}, 32'(bus.Winner), 0);
    chk({tag, "_draw"},   32'(bus.Draw), 0);
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    Reset_n         = 1'b0;
    bus.Reset_Game  = 1'b0;
    bus.Reset_Round = 1'b0;
    bus.Player_Dead = 4'b0000;
    bus.keycode     = 8'h00;
    step(2);
    chk_reset_outputs("rst");
    Reset_n = 1'b1;
    step(1);

    // menu navigation with wrap and held-key suppression
    press(8'h52); chk("up1", 32'(bus.menu_cursor), 2); release_key();
    press(8'h1A); chk("up2", 32'(bus.menu_cursor), 3); release_key();
    press(8'h52); chk("up_wrap", 32'(bus.menu_cursor), 1);
    release_key();
    press(8'h52); step(9);
    chk("up_held", 32'(bus.menu_cursor), 2);
    release_key();
    press(8'h51); chk("down1", 32'(bus.menu_cursor), 1); release_key();
    press(8'h16); chk("down_wrap", 32'(bus.menu_cursor), 3); release_key();
    press(8'h52); release_key();
    press(8'h52); chk("cursor2", 32'(bus.menu_cursor), 2); release_key();

    // enter: one reload pulse, map latched
    press(8'h28);
    chk("enter_state", 32'(bus.Game_State), 1);
    chk("enter_load",  32'(bus.load_background), 1);
    chk("enter_bg",    32'(bus.background_select), 2);
    step(1);
    chk("enter_held_state", 32'(bus.Game_State), 1);
    chk("enter_load_off",   32'(bus.load_background), 0);
    release_key();
    press(8'h04);
    chk("start_state", 32'(bus.Game_State), 2);
    chk("start_load",  32'(bus.load_background), 0);
    chk("start_bg",    32'(bus.background_select), 2);
    release_key();

    // successive deaths, player 1 survives
    bus.Player_Dead = 4'b0001; step(1);
    chk("alive_1110", 32'(bus.Alive), 32'hE);
    chk("still_started", 32'(bus.Game_State), 2);
    bus.Player_Dead = 4'b0100; step(1);
    chk("alive_1010", 32'(bus.Alive), 32'hA);
    bus.Player_Dead = 4'b1000; step(1);
    chk("r1_state",  32'(bus.Game_State), 3);
    chk("r1_winner", 32'(bus.Winner), 1);
    chk("r1_scores", 32'(bus.Scores), 32'h04);
    chk("r1_alive",  32'(bus.Alive), 32'h2);
    chk("r1_draw",   32'(bus.Draw), 0);
    bus.Player_Dead = 4'b0010; step(1);
    chk("dead_ignored_state", 32'(bus.Game_State), 3);
    chk("dead_ignored_alive", 32'(bus.Alive), 32'h2);
    bus.Player_Dead = 4'b0000;

    press(8'h04);
    chk("r2_paused", 32'(bus.Game_State), 1);
    chk("r2_load",   32'(bus.load_background), 1);
    chk("r2_alive",  32'(bus.Alive), 32'hF);
    release_key();
    press(8'h04); release_key();

    // simultaneous death of the last two players is a draw
    bus.Player_Dead = 4'b0011; step(1);
    chk("draw_pre_alive", 32'(bus.Alive), 32'hC);
    bus.Player_Dead = 4'b1100; step(1);
    chk("draw_state",  32'(bus.Game_State), 3);
    chk("draw_flag",   32'(bus.Draw), 1);
    chk("draw_scores", 32'(bus.Scores), 32'h04);
    bus.Player_Dead = 4'b0000;
    press(8'h04);
    chk("draw_cleared", 32'(bus.Draw), 0);
    release_key();
    press(8'h04); release_key();

    // Reset_Round beats a winning death in the same cycle
    bus.Player_Dead = 4'b1110;
    bus.Reset_Round = 1'b1;
    step(1);
    chk("rr_state",  32'(bus.Game_State), 1);
    chk("rr_load",   32'(bus.load_background), 1);
    chk("rr_scores", 32'(bus.Scores), 32'h04);
    chk("rr_alive",  32'(bus.Alive), 32'hF);
    bus.Reset_Round = 1'b0;
    bus.Player_Dead = 4'b0000;
    step(1);
    chk("rr_load_off", 32'(bus.load_background), 0);

    // player 0 takes two rounds and the match
    press(8'h04); release_key();
    bus.Player_Dead = 4'b1110; step(1);
    chk("p0_r1_scores", 32'(bus.Scores), 32'h05);
    chk("p0_r1_state",  32'(bus.Game_State), 3);
    bus.Player_Dead = 4'b0000;
    press(8'h04); release_key();
    press(8'h04); release_key();
    bus.Player_Dead = 4'b1110; step(1);
    chk("match_state",  32'(bus.Game_State), 4);
    chk("match_winner", 32'(bus.Winner), 0);
    chk("match_scores", 32'(bus.Scores), 32'h06);
    chk("match_bg",     32'(bus.background_select), 0);
    bus.Player_Dead = 4'b0000;
    press(8'h04);
    chk("menu_state",  32'(bus.Game_State), 0);
    chk("menu_load",   32'(bus.load_background), 1);
    chk("menu_bg",     32'(bus.background_select), 0);
    chk("menu_scores", 32'(bus.Scores), 32'h06);
    release_key();

    // Reset_Game overrides a simultaneous key in ROUND_OVER
    press(8'h28);
    chk("enter2_scores", 32'(bus.Scores), 0);
    release_key();
    press(8'h04); release_key();
    bus.Player_Dead = 4'b0111; step(1);
    chk("p3_scores", 32'(bus.Scores), 32'h40);
    bus.Player_Dead = 4'b0000;
    bus.Reset_Game  = 1'b1;
    press(8'h04);
    chk("rg_state",  32'(bus.Game_State), 0);
    chk("rg_scores", 32'(bus.Scores), 0);
    chk("rg_load",   32'(bus.load_background), 0);
    chk("rg_cursor", 32'(bus.menu_cursor), 2);
    chk("rg_bg",     32'(bus.background_select), 0);
    bus.Reset_Game = 1'b0;
    release_key();

    // asynchronous reset in the middle of a round
    press(8'h28); release_key();
    press(8'h04); release_key();
    bus.Player_Dead = 4'b0001; step(1);
    chk("pre_async_alive", 32'(bus.Alive), 32'hE);
    bus.Player_Dead = 4'b0000;
    Reset_n = 1'b0;
    #2;
    chk_reset_outputs("async");
    Reset_n = 1'b1;
    step(1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
